mips_muldiv: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers, executing MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/mips_muldiv.sv | 172 +++++++++++++++++
 tb/tb_mips_muldiv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; radix-2 shift-add multiply and restoring divide share one adder.
// Latency WIDTH+1 edges from start to done_o; commands are accepted only in IDLE, and flush_i abandons the op without a HI/LO write.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_q, acc_d, wrk_q, wrk_d, opnd_q, opnd_d;
    logic             div_q, div_d, nquo_q, nquo_d, nrem_q, nrem_d;

    logic             cmd_muldiv, cmd_signed, cmd_div, sa, sb, start_ok;
    logic [WIDTH:0]   shifted, add_x, add_y;
    logic             add_ci;
    logic [WIDTH+1:0] add_res;
    logic [WIDTH-1:0] acc_nx, wrk_nx, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign cmd_muldiv = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd3) || (op_i == 3'd4);
    assign cmd_signed = (op_i == 3'd1) || (op_i == 3'd3);
    assign cmd_div    = (op_i == 3'd3) || (op_i == 3'd4);
    assign sa         = cmd_signed & a_i[WIDTH-1];
    assign sb         = cmd_signed & b_i[WIDTH-1];
    assign start_ok   = start_i & ~flush_i & (state_q == S_IDLE);

    // Shared adder: acc + multiplicand for multiply, (rem<<1|bit) - divisor for divide
    always_comb begin
        shifted = {acc_q, wrk_q[WIDTH-1]};
        if (div_q) begin
            add_x  = shifted;
            add_y  = ~{1'b0, opnd_q};
            add_ci = 1'b1;
        end else begin
            add_x  = {1'b0, acc_q};
            add_y  = wrk_q[0] ? {1'b0, opnd_q} : '0;
            add_ci = 1'b0;
        end
    end

    assign add_res = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_ci};

    always_comb begin
        if (div_q) begin
            acc_nx = add_res[WIDTH+1] ? add_res[WIDTH-1:0] : shifted[WIDTH-1:0];
            wrk_nx = {wrk_q[WIDTH-2:0], add_res[WIDTH+1]};
        end else begin
            acc_nx = add_res[WIDTH:1];
            wrk_nx = {add_res[0], wrk_q[WIDTH-1:1]};
        end
    end

    assign prod   = {acc_nx, wrk_nx};
    assign prod_s = nquo_q ? -prod : prod;

    always_comb begin
        if (div_q) begin
            res_lo = nquo_q ? -wrk_nx : wrk_nx;
            res_hi = nrem_q ? -acc_nx : acc_nx;
        end else begin
            {res_hi, res_lo} = prod_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            wrk_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            nquo_q  <= 1'b0;
            nrem_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            nquo_q  <= nquo_d;
            nrem_q  <= nrem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok && cmd_muldiv) state_d = S_RUN;
            S_RUN:   if (flush_i) state_d = S_IDLE;
                     else if (count_q == LAST) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == S_RUN);
        done_o = (state_q == S_DONE);
    end

    always_comb begin
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        nquo_d  = nquo_q;
        nrem_d  = nrem_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok && cmd_muldiv) begin
                    acc_d   = '0;
                    wrk_d   = sa ? -a_i : a_i;
                    opnd_d  = sb ? -b_i : b_i;
                    div_d   = cmd_div;
                    // Divide-by-zero keeps the quotient all ones and the remainder equal to the dividend
                    nquo_d  = (sa ^ sb) & ~(cmd_div && (b_i == '0));
                    nrem_d  = sa;
                    count_d = '0;
                end else if (start_ok && op_i == 3'd5) begin
                    hi_d = a_i;
                end else if (start_ok && op_i == 3'd6) begin
                    lo_d = a_i;
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    count_d = '0;
                end else begin
                    acc_d   = acc_nx;
                    wrk_d   = wrk_nx;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: begin
                if (flush_i) count_d = '0;
            end
        endcase
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Randomised and directed bench for mips_muldiv against an arithmetic reference and a cycle-count model.
module tb_mips_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op_i;
    logic        start_i;
    logic [31:0] a_i, b_i;
    logic        flush_i;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sq, sr;
        logic [63:0] q64, r64;
        case (op)
            3'd1: begin
                sq = longint'($signed(a)) * longint'($signed(b));
                return sq;
            end
            3'd2: return 64'(a) * 64'(b);
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                q64 = sq;
                r64 = sr;
                return {r64[31:0], q64[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Timing model: an accepted mul/div writes HI/LO 32 edges after the start edge, then done for one cycle
    int          m_rem  = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_rem = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        end else if (m_rem > 0) begin
            if (flush_i) m_rem = 0;
            else begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start_i && !flush_i) begin
            if (op_i >= 3'd1 && op_i <= 3'd4) begin
                m_pend = ref_res(op_i, a_i, b_i);
                m_rem  = 32;
            end else if (op_i == 3'd5) m_hi = a_i;
            else if (op_i == 3'd6) m_lo = a_i;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy_o), 64'(m_rem > 0));
            chk("done", 64'(done_o), 64'(m_done));
            chk("hi",   64'(hi_o),   64'(m_hi));
            chk("lo",   64'(lo_o),   64'(m_lo));
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_at);
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        busy_n = 0; done_at = 0;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            start_i = 1'b0; a_i = $urandom; b_i = $urandom;
            if (busy_o) busy_n++;
            if (done_o && done_at == 0) done_at = i;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    int bn, da, dcnt;

    initial begin
        rst = 1'b0; start_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_hi", 64'(hi_o), 64'h0);
        chk("reset_busy", 64'(busy_o), 64'h0);
        rst = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, bn, da);
        chk("mult_busy_cycles", 64'(bn), 64'd32);
        chk("mult_done_cycle", 64'(da), 64'd33);
        chk("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo_o), 64'hFFFF_FFF1);

        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, da);
        chk("multu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd4, 32'd100, 32'd7, bn, da);
        chk("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, bn, da);
        chk("div_neg_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bn, da);
        chk("div_ovf_hilo", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        run_op(3'd4, 32'h1234, 32'h0, bn, da);
        chk("divu_zero_hilo", {hi_o, lo_o}, 64'h0000_1234_FFFF_FFFF);
        chk("divu_zero_done", 64'(da), 64'd33);

        @(negedge clk); start_i = 1'b1; op_i = 3'd5; a_i = 32'hA5A5_A5A5;
        @(negedge clk); start_i = 1'b0;
        chk("mthi", 64'(hi_o), 64'hA5A5_A5A5);
        chk("mthi_no_done", 64'(done_o), 64'h0);
        @(negedge clk); start_i = 1'b1; op_i = 3'd1; a_i = 32'd3; b_i = 32'd4;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            start_i = (i == 5); op_i = (i == 5) ? 3'd6 : 3'd1; a_i = 32'hDEAD_BEEF;
        end
        chk("mtlo_ignored", {hi_o, lo_o}, {32'd0, 32'd12});

        @(negedge clk); start_i = 1'b1; op_i = 3'd2; a_i = 32'd7; b_i = 32'd9;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); start_i = 1'b0;
        end
        flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'h0);
        dcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_o) dcnt++;
        end
        chk("flush_no_done", 64'(dcnt), 64'h0);
        chk("flush_hilo", {hi_o, lo_o}, {32'd0, 32'd12});

        @(negedge clk); start_i = 1'b1; op_i = 3'd4; a_i = 32'd100; b_i = 32'd7;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); start_i = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        chk("rst_mid_busy", 64'(busy_o), 64'h0);
        chk("rst_mid_hilo", {hi_o, lo_o}, 64'h0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst     = ($urandom % 800) != 0;
            start_i = ($urandom % 3) == 0;
            op_i    = 3'($urandom % 8);
            a_i     = pick();
            b_i     = pick();
            flush_i = ($urandom % 150) == 0;
        end
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
